gshare_branch_predictor: RTL and testbench

- Parametrised successor to the fixed 2-bit bimodal predictor.
- Selectable index mode: bimodal, gshare or gselect.
- Configurable PHT depth, counter width and history length.
- Speculative global history register (GHR) with checkpoint out and restore on mispredict.
- Sits in the fetch stage; lookups come from fetch, training and recovery come from commit.

---
 rtl/gshare_branch_predictor_pkg.sv | 22 ++
 rtl/bp_sat_counter_table.sv | 41 ++++
 rtl/gshare_branch_predictor.sv | 122 ++++++++++++
 tb/tb_gshare_branch_predictor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and defaults for the gshare/bimodal/gselect branch predictor.
// Holds the index-mode enum, default geometry and the counter reset value.
package module_types;

  typedef enum logic [1:0] {
    BP_BIMODAL = 2'd0,
    BP_GSHARE  = 2'd1,
    BP_GSELECT = 2'd2
  } bp_mode_t;

  localparam int BP_PHT_IDX_W = 8;
  localparam int BP_CTR_W     = 2;
  localparam int BP_GHR_W     = 4;

  // Weakly-taken reset value: only the counter MSB set.
  function automatic logic [31:0] bp_ctr_init(input int ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  localparam logic [BP_CTR_W-1:0] BP_CTR_INIT = BP_CTR_W'(bp_ctr_init(BP_CTR_W));

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: 2^IDX_W saturating counters with one combinational
// read port and one saturating update port; every entry resets to weakly taken.
module bp_sat_counter_table
  import module_types::*;
#(
  parameter int IDX_W = BP_PHT_IDX_W,
  parameter int CTR_W = BP_CTR_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_inc
);

  localparam int               ENTRIES  = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bp_ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] r_mem [ENTRIES];

  // A same-cycle read of the entry being written sees the old value.
  assign o_rd_ctr = r_mem[i_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= CTR_INIT;
      end
    end else if (i_wr_en) begin
      if (i_wr_inc) begin
        if (r_mem[i_wr_idx] != CTR_MAX) r_mem[i_wr_idx] <= r_mem[i_wr_idx] + 1'b1;
      end else begin
        if (r_mem[i_wr_idx] != '0) r_mem[i_wr_idx] <= r_mem[i_wr_idx] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage direction predictor with selectable bimodal/gshare/gselect
// indexing and a speculative GHR. Define BP_STATS_EN to add lookup/mispredict counters.
module gshare_branch_predictor
  import module_types::*;
#(
  parameter int PHT_IDX_W = BP_PHT_IDX_W,
  parameter int CTR_W     = BP_CTR_W,
  parameter int GHR_W     = BP_GHR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_mode,
  input  logic                 i_pred_req,
  input  logic [31:0]          i_inst_pc,
  output logic                 o_pred_valid,
  output logic                 o_pred,
  output logic [PHT_IDX_W-1:0] o_pred_idx,
  output logic [GHR_W-1:0]     o_pred_ghr,
  input  logic                 i_w_en,
  input  logic [PHT_IDX_W-1:0] i_commit_idx,
  input  logic [GHR_W-1:0]     i_commit_ghr,
  input  logic                 i_taken,
  input  logic                 i_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          o_stat_lookups,
  output logic [31:0]          o_stat_mispredicts
`endif
);

  logic [GHR_W-1:0]     r_spec_ghr;
  logic [PHT_IDX_W-1:0] w_pc;
  logic [PHT_IDX_W-1:0] w_idx;
  logic [CTR_W-1:0]     w_rd_ctr;
  logic                 w_pred_bit;
  logic                 w_recover;
  logic [GHR_W-1:0]     w_ghr_shift;
  logic [GHR_W-1:0]     w_ghr_restore;
  logic                 w_unused;

  assign w_pc       = i_inst_pc[2 +: PHT_IDX_W];
  assign w_pred_bit = w_rd_ctr[CTR_W-1];
  assign w_recover  = i_w_en & i_mispredict;
  assign w_unused   = ^{i_inst_pc[1:0], i_inst_pc[31:2+PHT_IDX_W], w_rd_ctr, i_commit_ghr};

  always_comb begin
    w_idx = w_pc;
    case (i_mode)
      BP_GSHARE:  w_idx = w_pc ^ {{(PHT_IDX_W-GHR_W){1'b0}}, r_spec_ghr};
      BP_GSELECT: w_idx = {i_inst_pc[2 +: PHT_IDX_W-GHR_W], r_spec_ghr};
      default:    w_idx = w_pc;
    endcase
  end

  // A one-bit history has nothing to shift; it simply takes the newest outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign w_ghr_shift   = w_pred_bit;
      assign w_ghr_restore = i_taken;
    end else begin : g_ghr_multi
      assign w_ghr_shift   = {r_spec_ghr[GHR_W-2:0], w_pred_bit};
      assign w_ghr_restore = {i_commit_ghr[GHR_W-2:0], i_taken};
    end
  endgenerate

  bp_sat_counter_table #(
    .IDX_W(PHT_IDX_W),
    .CTR_W(CTR_W)
  ) u_pht (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rd_idx(w_idx),
    .o_rd_ctr(w_rd_ctr),
    .i_wr_en (i_w_en),
    .i_wr_idx(i_commit_idx),
    .i_wr_inc(i_taken)
  );

  // Commit-side recovery wins over the fetch-side speculative shift.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_spec_ghr <= '0;
    end else if (w_recover) begin
      r_spec_ghr <= w_ghr_restore;
    end else if (i_pred_req) begin
      r_spec_ghr <= w_ghr_shift;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pred_valid <= 1'b0;
      o_pred       <= 1'b0;
      o_pred_idx   <= '0;
      o_pred_ghr   <= '0;
    end else begin
      o_pred_valid <= i_pred_req;
      if (i_pred_req) begin
        o_pred     <= w_pred_bit;
        o_pred_idx <= w_idx;
        o_pred_ghr <= r_spec_ghr;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_lookups     <= '0;
      o_stat_mispredicts <= '0;
    end else begin
      if (i_pred_req && (o_stat_lookups != 32'hFFFF_FFFF)) begin
        o_stat_lookups <= o_stat_lookups + 32'd1;
      end
      if (w_recover && (o_stat_mispredicts != 32'hFFFF_FFFF)) begin
        o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: a reference model pushes
// expected lookups to a scoreboard queue; they are popped when pred_valid should appear.
module tb_gshare_branch_predictor;

  localparam int IW = 8;
  localparam int CW = 2;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          predReq;
  logic [31:0]   instPc;
  logic          predValid;
  logic          pred;
  logic [IW-1:0] predIdx;
  logic [GW-1:0] predGhr;
  logic          wEn;
  logic [IW-1:0] commitIdx;
  logic [GW-1:0] commitGhr;
  logic          taken;
  logic          mispredict;
`ifdef BP_STATS_EN
  logic [31:0]   statLookups;
  logic [31:0]   statMispredicts;
  int            mLookups;
  int            mMispredicts;
`endif

  always #5 clk = ~clk;

  gshare_branch_predictor #(
    .PHT_IDX_W(IW),
    .CTR_W    (CW),
    .GHR_W    (GW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .i_pred_req  (predReq),
    .i_inst_pc   (instPc),
    .o_pred_valid(predValid),
    .o_pred      (pred),
    .o_pred_idx  (predIdx),
    .o_pred_ghr  (predGhr),
    .i_w_en      (wEn),
    .i_commit_idx(commitIdx),
    .i_commit_ghr(commitGhr),
    .i_taken     (taken),
    .i_mispredict(mispredict)
`ifdef BP_STATS_EN
    ,
    .o_stat_lookups    (statLookups),
    .o_stat_mispredicts(statMispredicts)
`endif
  );

  typedef struct {
    string         tag;
    logic          pred;
    logic [IW-1:0] idx;
    logic [GW-1:0] ghr;
  } exp_t;

  exp_t          sbq[$];
  int            mPht[256];
  logic [GW-1:0] mGhr;
  int            nChecks = 0;
  int            nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) mPht[i] = 2;
    mGhr = '0;
    sbq.delete();
`ifdef BP_STATS_EN
    mLookups     = 0;
    mMispredicts = 0;
`endif
  endtask

  function automatic logic [IW-1:0] modelIdx(input logic [1:0] md, input logic [31:0] pc);
    logic [IW-1:0] p;
    p = pc[2 +: IW];
    case (md)
      2'd1:    return p ^ {4'b0000, mGhr};
      2'd2:    return {pc[5:2], mGhr};
      default: return p;
    endcase
  endfunction

  // Pops one expected lookup whenever a prediction should be presented.
  task automatic checkOutput(input logic expValid, input string stepTag);
    exp_t e;
    checkVal({stepTag, ".valid"}, {31'd0, predValid}, {31'd0, expValid});
    if (expValid) begin
      nChecks++;
      assert (sbq.size() > 0) nPass++;
      else $error("[TB] FAIL %s.queue: observed empty expected 1 entry", stepTag);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkVal({e.tag, ".pred"}, {31'd0, pred}, {31'd0, e.pred});
        checkVal({e.tag, ".idx"}, {24'd0, predIdx}, {24'd0, e.idx});
        checkVal({e.tag, ".ghr"}, {28'd0, predGhr}, {28'd0, e.ghr});
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic req, input logic [31:0] pc,
                               input logic [1:0] md, input logic we, input logic [IW-1:0] cIdx,
                               input logic [GW-1:0] cGhr, input logic tk, input logic misp);
    exp_t          e;
    logic [IW-1:0] idx;
    logic          pb;
    predReq    = req;
    instPc     = pc;
    mode       = md;
    wEn        = we;
    commitIdx  = cIdx;
    commitGhr  = cGhr;
    taken      = tk;
    mispredict = misp;
    idx = modelIdx(md, pc);
    pb  = (mPht[idx] >= 2);
    if (req) begin
      e.tag = tag;
      e.pred = pb;
      e.idx = idx;
      e.ghr = mGhr;
      sbq.push_back(e);
    end
    if (we) begin
      if (tk && mPht[cIdx] < 3) mPht[cIdx]++;
      else if (!tk && mPht[cIdx] > 0) mPht[cIdx]--;
    end
    if (we && misp) mGhr = {cGhr[2:0], tk};
    else if (req)   mGhr = {mGhr[2:0], pb};
`ifdef BP_STATS_EN
    if (req) mLookups++;
    if (we && misp) mMispredicts++;
`endif
    @(posedge clk);
    @(negedge clk);
    predReq    = 1'b0;
    wEn        = 1'b0;
    mispredict = 1'b0;
    checkOutput(req, tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst = 1'b1; mode = '0; predReq = 1'b0; instPc = '0; wEn = 1'b0;
    commitIdx = '0; commitGhr = '0; taken = 1'b0; mispredict = 1'b0;
    @(negedge clk);
    doReset();
    checkVal("rst.valid", {31'd0, predValid}, 32'd0);
    checkVal("rst.pred", {31'd0, pred}, 32'd0);
    checkVal("rst.idx", {24'd0, predIdx}, 32'd0);
    checkVal("rst.ghr", {28'd0, predGhr}, 32'd0);

    // First lookup: weakly taken, bimodal index 0x04.
    applyStimulus("first", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("first.idxConst", {24'd0, predIdx}, 32'h04);
    applyStimulus("idle", 0, 32'h0, 2'd0, 0, '0, '0, 0, 0);

    // Counter training down to zero, then back up to weakly taken.
    applyStimulus("nt1", 0, 32'h0, 2'd0, 1, 8'h04, '0, 0, 0);
    applyStimulus("nt2", 0, 32'h0, 2'd0, 1, 8'h04, '0, 0, 0);
    applyStimulus("afterNt2", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("afterNt2.predConst", {31'd0, pred}, 32'd0);
    applyStimulus("nt3", 0, 32'h0, 2'd0, 1, 8'h04, '0, 0, 0);
    applyStimulus("tk1", 0, 32'h0, 2'd0, 1, 8'h04, '0, 1, 0);
    applyStimulus("afterTk1", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("afterTk1.predConst", {31'd0, pred}, 32'd0);
    applyStimulus("tk2", 0, 32'h0, 2'd0, 1, 8'h04, '0, 1, 0);
    applyStimulus("afterTk2", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("afterTk2.predConst", {31'd0, pred}, 32'd1);

    // History build-up from reset, then gshare on the fifth lookup.
    doReset();
    applyStimulus("hist0", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    applyStimulus("hist1", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    applyStimulus("hist3", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    applyStimulus("hist7", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("hist7.ghrConst", {28'd0, predGhr}, 32'h7);
    applyStimulus("gshare", 1, 32'h10, 2'd1, 0, '0, '0, 0, 0);
    checkVal("gshare.idxConst", {24'd0, predIdx}, 32'h0B);

    // Recovery to GHR 0x5, then gselect lookup.
    applyStimulus("recov5", 0, 32'h0, 2'd0, 1, 8'h80, 4'h2, 1, 1);
    applyStimulus("gselect", 1, 32'h40, 2'd2, 0, '0, '0, 0, 0);
    checkVal("gselect.idxConst", {24'd0, predIdx}, 32'h05);

    // Recovery coincident with a lookup; following lookup shows restored GHR.
    applyStimulus("sameCyc", 1, 32'h10, 2'd1, 1, 8'h20, 4'h3, 0, 1);
    applyStimulus("postRecov", 1, 32'h10, 2'd0, 0, '0, '0, 0, 0);
    checkVal("postRecov.ghrConst", {28'd0, predGhr}, 32'h6);

    // Mispredict without w_en leaves the GHR alone.
    applyStimulus("mispNoWen", 0, 32'h0, 2'd0, 0, '0, 4'hF, 1, 1);
    applyStimulus("afterMispNoWen", 1, 32'h44, 2'd3, 0, '0, '0, 0, 0);

    // Same-index read and write: lookup sees the old counter.
    applyStimulus("rdWr", 1, 32'h20, 2'd0, 1, 8'h08, '0, 0, 0);
    applyStimulus("rdWr2", 1, 32'h20, 2'd0, 1, 8'h08, '0, 0, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef BP_STATS_EN
    checkVal("stat.lookups", statLookups, 32'(mLookups));
    checkVal("stat.mispredicts", statMispredicts, 32'(mMispredicts));
`endif

    // Reset together with a lookup: the prediction must be dropped.
    rst = 1'b1;
    predReq = 1'b1;
    instPc = 32'h10;
    @(posedge clk);
    @(negedge clk);
    predReq = 1'b0;
    rst = 1'b0;
    modelReset();
    checkVal("midRst.valid", {31'd0, predValid}, 32'd0);
    checkVal("midRst.idx", {24'd0, predIdx}, 32'd0);
`ifdef BP_STATS_EN
    checkVal("midRst.lookups", statLookups, 32'd0);
    checkVal("midRst.mispredicts", statMispredicts, 32'd0);
`endif
    applyStimulus("postRst", 1, 32'h10, 2'd1, 0, '0, '0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
